// File: rtl/piezo_tone_seq_if.sv
// Request/tone bundle between the event sources, the tone sequencer and the PWM stage.
// The sequencer uses the slave side; the requester/observer uses the master side.
interface piezo_tone_seq_if;
    logic        ovr_spd;
    logic        batt_low;
    logic        en_steer;
    logic [20:0] max_cnt;
    logic [19:0] duty;
    logic        tone_on;
    logic        busy;

    modport master (
        output ovr_spd, batt_low, en_steer,
        input  max_cnt, duty, tone_on, busy
    );

    modport slave (
        input  ovr_spd, batt_low, en_steer,
        output max_cnt, duty, tone_on, busy
    );
endinterface

// File: rtl/piezo_tone_seq.sv
// Alarm/chirp tone sequencer: arbitrates overspeed, battery-low and steer chirp requests
// and drives a registered PWM period/duty pair for the piezo stage.
module piezo_tone_seq #(
    parameter logic [23:0] NOTE_CYC    = 24'd12_500_000,
    parameter logic [23:0] GAP_CYC     = 24'd2_500_000,
    parameter logic [20:0] PERIOD_LOW  = 21'd113_636,
    parameter logic [20:0] PERIOD_MID  = 21'd75_757,
    parameter logic [20:0] PERIOD_HIGH = 21'd56_818
) (
    input  logic           clk,
    input  logic           rst_n,
    piezo_tone_seq_if.slave tone
);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
    typedef enum logic [1:0] {PAT_OVR, PAT_BATT, PAT_CHIRP} pat_t;

    state_t      state, nxt_state;
    pat_t        pat, nxt_pat;
    logic [2:0]  step, nxt_step;
    logic [1:0]  rep, nxt_rep;
    logic [23:0] dur_cnt, nxt_cnt;
    logic        steer_pend, nxt_pend;
    logic        steer_q;
    logic        steer_rise;
    logic [20:0] nxt_period;

    assign steer_rise = tone.en_steer & ~steer_q;

    always_comb begin
        nxt_state = state;
        nxt_pat   = pat;
        nxt_step  = step;
        nxt_rep   = rep;
        nxt_cnt   = dur_cnt - 24'd1;
        nxt_pend  = steer_pend | steer_rise;
        case (state)
            IDLE: begin
                nxt_step = 3'd0;
                nxt_cnt  = NOTE_CYC - 24'd1;
                if (tone.ovr_spd) begin
                    nxt_state = NOTE;
                    nxt_pat   = PAT_OVR;
                end else if (tone.batt_low) begin
                    nxt_state = NOTE;
                    nxt_pat   = PAT_BATT;
                end else if (nxt_pend) begin
                    nxt_state = NOTE;
                    nxt_pat   = PAT_CHIRP;
                    nxt_pend  = 1'b0;
                end else begin
                    nxt_cnt = '0;
                end
            end
            default: begin
                if (tone.ovr_spd && pat != PAT_OVR) begin
                    // Overspeed abandons whatever is playing; an interrupted chirp is re-queued.
                    nxt_state = NOTE;
                    nxt_pat   = PAT_OVR;
                    nxt_step  = 3'd0;
                    nxt_cnt   = NOTE_CYC - 24'd1;
                    if (pat == PAT_CHIRP) nxt_pend = 1'b1;
                end else if (dur_cnt == 24'd0) begin
                    if (pat == PAT_BATT && step == 3'd5 && rep != 2'd0) begin
                        // Battery pause is four note-lengths, too long for one dur_cnt load.
                        nxt_rep = rep - 2'd1;
                        nxt_cnt = NOTE_CYC - 24'd1;
                    end else if ((pat == PAT_OVR  && !tone.ovr_spd)  ||
                                 (pat == PAT_BATT && !tone.batt_low) ||
                                 (pat == PAT_CHIRP && step == 3'd2)) begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                    end else if (state == NOTE) begin
                        nxt_state = GAP;
                        nxt_step  = step + 3'd1;
                        if (pat == PAT_BATT && step == 3'd4) begin
                            nxt_cnt = NOTE_CYC - 24'd1;
                            nxt_rep = 2'd3;
                        end else begin
                            nxt_cnt = GAP_CYC - 24'd1;
                        end
                    end else begin
                        nxt_state = NOTE;
                        nxt_cnt   = NOTE_CYC - 24'd1;
                        nxt_step  = ((pat == PAT_OVR && step == 3'd3) ||
                                     (pat == PAT_BATT && step == 3'd5)) ? 3'd0 : step + 3'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        nxt_period = PERIOD_LOW;
        case (nxt_pat)
            PAT_OVR:   nxt_period = (nxt_step == 3'd0) ? PERIOD_HIGH : PERIOD_LOW;
            PAT_CHIRP: nxt_period = (nxt_step == 3'd0) ? PERIOD_MID  : PERIOD_HIGH;
            default:   nxt_period = PERIOD_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pat          <= PAT_OVR;
            step         <= 3'd0;
            rep          <= 2'd0;
            dur_cnt      <= '0;
            steer_pend   <= 1'b0;
            steer_q      <= 1'b0;
            tone.max_cnt <= PERIOD_LOW;
            tone.duty    <= '0;
            tone.tone_on <= 1'b0;
            tone.busy    <= 1'b0;
        end else begin
            state      <= nxt_state;
            pat        <= nxt_pat;
            step       <= nxt_step;
            rep        <= nxt_rep;
            dur_cnt    <= nxt_cnt;
            steer_pend <= nxt_pend;
            steer_q    <= tone.en_steer;
            // Outputs follow the next state so a decision shows up one cycle later.
            if (nxt_state == NOTE) begin
                tone.max_cnt <= nxt_period;
                tone.duty    <= nxt_period[20:1];
                tone.tone_on <= 1'b1;
            end else begin
                tone.duty    <= '0;
                tone.tone_on <= 1'b0;
            end
            tone.busy <= (nxt_state != IDLE);
        end
    end

endmodule

// File: tb/tb_piezo_tone_seq.sv
// Bench for piezo_tone_seq: a timeline-based reference model feeds a scoreboard that a
// separate monitor drains every cycle against the DUT outputs.
module tb_piezo_tone_seq;

    localparam int          NOTE   = 100;
    localparam int          GAP    = 20;
    localparam logic [20:0] P_LOW  = 21'd1000;
    localparam logic [20:0] P_MID  = 21'd750;
    localparam logic [20:0] P_HIGH = 21'd500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    piezo_tone_seq_if tif();

    piezo_tone_seq #(
        .NOTE_CYC   (24'd100),
        .GAP_CYC    (24'd20),
        .PERIOD_LOW (P_LOW),
        .PERIOD_MID (P_MID),
        .PERIOD_HIGH(P_HIGH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tone (tif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Reference model: each pattern is expanded into a per-cycle timeline of tuples.
    typedef struct packed {
        logic [20:0] per;
        logic        snd;
        logic        bsy;
        logic        fin;
    } tup_t;
    typedef enum int {M_NONE, M_OVR, M_BATT, M_CHIRP} mpat_t;

    tup_t        tl[$];
    logic [42:0] sb[$];
    tup_t        cur = '0;
    mpat_t       mpat = M_NONE;
    logic        pend = 1'b0;
    logic        prev_en = 1'b0;
    logic [20:0] last_per = P_LOW;

    task automatic seg(input int len, input logic [20:0] per, input logic snd);
        tup_t t;
        for (int i = 0; i < len; i++) begin
            t.per = per;
            t.snd = snd;
            t.bsy = 1'b1;
            t.fin = (i == len - 1);
            tl.push_back(t);
        end
    endtask

    task automatic start(input mpat_t p);
        tup_t idle_t;
        idle_t = '0;
        mpat = p;
        case (p)
            M_OVR: begin
                seg(NOTE, P_HIGH, 1'b1); seg(GAP, '0, 1'b0);
                seg(NOTE, P_LOW, 1'b1);  seg(GAP, '0, 1'b0);
            end
            M_BATT: begin
                seg(NOTE, P_LOW, 1'b1); seg(GAP, '0, 1'b0);
                seg(NOTE, P_LOW, 1'b1); seg(GAP, '0, 1'b0);
                seg(NOTE, P_LOW, 1'b1); seg(4 * NOTE, '0, 1'b0);
            end
            M_CHIRP: begin
                seg(NOTE, P_MID, 1'b1); seg(GAP, '0, 1'b0);
                seg(NOTE, P_HIGH, 1'b1);
                tl.push_back(idle_t);
            end
            default: tl.push_back(idle_t);
        endcase
    endtask

    initial begin : model
        logic rise;
        tup_t idle_t;
        idle_t = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                tl.delete();
                cur = '0;
                mpat = M_NONE;
                pend = 1'b0;
                prev_en = 1'b0;
                last_per = P_LOW;
            end else begin
                rise = tif.en_steer && !prev_en;
                prev_en = tif.en_steer;
                if (rise) pend = 1'b1;
                if (cur.bsy && mpat != M_OVR && tif.ovr_spd) begin
                    if (mpat == M_CHIRP) pend = 1'b1;
                    tl.delete();
                    start(M_OVR);
                end else if (cur.bsy && cur.fin &&
                             ((mpat == M_OVR && !tif.ovr_spd) || (mpat == M_BATT && !tif.batt_low))) begin
                    tl.delete();
                    mpat = M_NONE;
                    tl.push_back(idle_t);
                end else if (tl.size() == 0) begin
                    if (cur.bsy) start(mpat);
                    else if (tif.ovr_spd) start(M_OVR);
                    else if (tif.batt_low) start(M_BATT);
                    else if (pend) begin
                        pend = 1'b0;
                        start(M_CHIRP);
                    end else tl.push_back(idle_t);
                end
                cur = tl.pop_front();
                if (cur.snd) last_per = cur.per;
                sb.push_back({last_per, cur.snd ? cur.per[20:1] : 20'd0, cur.snd, cur.bsy});
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sb.delete();
                check("reset_outputs", {tif.max_cnt, tif.duty, tif.tone_on, tif.busy},
                      {P_LOW, 20'd0, 1'b0, 1'b0});
            end else if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard_underflow at %0t: got no expected entry, required one", $time);
            end else begin
                check("tone_outputs", {tif.max_cnt, tif.duty, tif.tone_on, tif.busy}, sb.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        tif.ovr_spd  = 1'b0;
        tif.batt_low = 1'b0;
        tif.en_steer = 1'b0;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1000);

        // single chirp
        tif.en_steer = 1'b1; cyc(5); tif.en_steer = 1'b0; cyc(300);

        // battery pattern, dropped during the second note of the second round
        tif.batt_low = 1'b1; cyc(900); tif.batt_low = 1'b0; cyc(200);

        // overspeed preempts battery; two steer edges merge into one chirp afterwards
        tif.batt_low = 1'b1; cyc(50);
        tif.ovr_spd = 1'b1; cyc(100);
        tif.en_steer = 1'b1; cyc(3); tif.en_steer = 1'b0; cyc(3);
        tif.en_steer = 1'b1; cyc(3); tif.en_steer = 1'b0; cyc(300);
        tif.batt_low = 1'b0; cyc(50);
        tif.ovr_spd = 1'b0; cyc(600);

        // async reset in the middle of a chirp note
        tif.en_steer = 1'b1; cyc(30);
        @(posedge clk); #2;
        check("note_before_reset", {tif.max_cnt, tif.tone_on}, {P_MID, 1'b1});
        rst_n = 1'b0;
        #1;
        check("async_rst_duty", tif.duty, 20'd0);
        check("async_rst_tone_on", tif.tone_on, 1'b0);
        check("async_rst_busy", tif.busy, 1'b0);
        check("async_rst_max_cnt", tif.max_cnt, P_LOW);
        tif.en_steer = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(300);

        // randomized request traffic
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ($urandom_range(299) == 0) tif.ovr_spd  = ~tif.ovr_spd;
            if ($urandom_range(199) == 0) tif.batt_low = ~tif.batt_low;
            if ($urandom_range(49) == 0)  tif.en_steer = ~tif.en_steer;
        end
        tif.ovr_spd  = 1'b0;
        tif.batt_low = 1'b0;
        tif.en_steer = 1'b0;
        cyc(1200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
